// File: rtl/tank_round_ctrl_if.sv
// tank_round_ctrl_if: bundle between the round controller and its neighbours.
// master = collision logic / tank blocks / bench side, slave = tank_round_ctrl.
interface tank_round_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               start;
    logic               hit_red;
    logic               hit_blue;
    logic               red_explosion_ack;
    logic               blue_explosion_ack;
    logic               red_explosion_flag;
    logic               blue_explosion_flag;
    logic               red_move_en;
    logic               blue_move_en;
    logic               red_boom;
    logic               blue_boom;
    logic [2:0]         red_frame;
    logic [2:0]         blue_frame;
    logic [SCORE_W-1:0] red_score;
    logic [SCORE_W-1:0] blue_score;
    logic               game_over;
    logic               winner;
    logic               draw;

    modport master (
        output start, hit_red, hit_blue, red_explosion_ack, blue_explosion_ack,
        input  red_explosion_flag, blue_explosion_flag, red_move_en, blue_move_en,
               red_boom, blue_boom, red_frame, blue_frame, red_score, blue_score,
               game_over, winner, draw
    );

    modport slave (
        input  start, hit_red, hit_blue, red_explosion_ack, blue_explosion_ack,
        output red_explosion_flag, blue_explosion_flag, red_move_en, blue_move_en,
               red_boom, blue_boom, red_frame, blue_frame, red_score, blue_score,
               game_over, winner, draw
    );
endinterface

// File: rtl/tank_round_ctrl.sv
// tank_round_ctrl: per-tank explode/respawn sequencing, movement gating,
// scoring and winner detection for the two-tank game.
// Optional feature: define RESPAWN_INVULN_EN to build the post-respawn
// invulnerability state (INVULN_TICKS ticks of hit immunity after ack).
// Tank index 0 = red, 1 = blue throughout.
module tank_round_ctrl #(
    parameter int TICK_CNT      = 500000,
    parameter int EXPLODE_TICKS = 32,
    parameter int INVULN_TICKS  = 64,
    parameter int WIN_SCORE     = 9,
    parameter int SCORE_W       = 4
) (
    input  logic                 clk25,
    input  logic                 reset,
    tank_round_ctrl_if.slave     bus
);
    localparam int TW        = (TICK_CNT < 1) ? 1 : $clog2(TICK_CNT + 1);
    localparam int EW        = $clog2(EXPLODE_TICKS);
    localparam int FRAME_DIV = EXPLODE_TICKS / 8;
`ifdef RESPAWN_INVULN_EN
    localparam int IW        = (INVULN_TICKS < 2) ? 1 : $clog2(INVULN_TICKS);
`endif

    localparam logic [1:0] ST_ALIVE   = 2'd0;
    localparam logic [1:0] ST_EXPLODE = 2'd1;
    localparam logic [1:0] ST_RESPAWN = 2'd2;
    localparam logic [1:0] ST_INVULN  = 2'd3;

    if (EXPLODE_TICKS < 8 || (EXPLODE_TICKS % 8) != 0 || INVULN_TICKS < 1 ||
        WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_params
        $error("tank_round_ctrl: illegal parameter combination");
    end

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [1:0]         state [2];
    logic [EW-1:0]      ecnt  [2];
`ifdef RESPAWN_INVULN_EN
    logic [IW-1:0]      icnt  [2];
`endif
    logic [1:0]         hit_in;
    logic [1:0]         ack_in;
    logic [1:0]         hit_ok;
    logic [1:0]         reach;
    logic [SCORE_W-1:0] score_q [2];
    logic [SCORE_W-1:0] score_d [2];
    logic               game_over_q;
    logic               winner_q;
    logic               draw_q;
    logic               start_ok;

    assign tick = (tick_cnt == TW'(TICK_CNT));

    // Free-running tick divider, wraps after TICK_CNT.
    always_ff @(posedge clk25) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

    // Hit qualification and saturating opponent score update.
    always_comb begin
        hit_in   = {bus.hit_blue, bus.hit_red};
        ack_in   = {bus.blue_explosion_ack, bus.red_explosion_ack};
        start_ok = bus.start & game_over_q;
        for (int unsigned i = 0; i < 2; i++) begin
            hit_ok[i] = hit_in[i] && (state[i] == ST_ALIVE) && !game_over_q;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            score_d[i] = score_q[i];
            reach[i]   = 1'b0;
            if (hit_ok[1-i] && score_q[i] != SCORE_W'(WIN_SCORE)) begin
                score_d[i] = score_q[i] + 1'b1;
                reach[i]   = (score_d[i] == SCORE_W'(WIN_SCORE));
            end
        end
    end

    // Per-tank ALIVE -> EXPLODE -> RESPAWN (-> INVULN) -> ALIVE sequencer.
    always_ff @(posedge clk25) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (reset) begin
                state[i] <= ST_ALIVE;
                ecnt[i]  <= '0;
`ifdef RESPAWN_INVULN_EN
                icnt[i]  <= '0;
`endif
            end else begin
                case (state[i])
                    ST_ALIVE: begin
                        if (hit_ok[i]) begin
                            state[i] <= ST_EXPLODE;
                            ecnt[i]  <= '0;
                        end
                    end
                    ST_EXPLODE: begin
                        if (tick) begin
                            if (ecnt[i] == EW'(EXPLODE_TICKS - 1)) begin
                                state[i] <= ST_RESPAWN;
                                ecnt[i]  <= '0;
                            end else begin
                                ecnt[i]  <= ecnt[i] + 1'b1;
                            end
                        end
                    end
                    ST_RESPAWN: begin
                        if (ack_in[i]) begin
`ifdef RESPAWN_INVULN_EN
                            state[i] <= ST_INVULN;
                            icnt[i]  <= '0;
`else
                            state[i] <= ST_ALIVE;
`endif
                        end
                    end
                    ST_INVULN: begin
`ifdef RESPAWN_INVULN_EN
                        if (tick) begin
                            if (icnt[i] == IW'(INVULN_TICKS - 1)) state[i] <= ST_ALIVE;
                            else                                  icnt[i]  <= icnt[i] + 1'b1;
                        end
`else
                        state[i] <= ST_ALIVE;
`endif
                    end
                    default: state[i] <= ST_ALIVE;
                endcase
            end
        end
    end

    // Scores, game-over latch, winner/draw; start only clears a finished round.
    always_ff @(posedge clk25) begin
        if (reset || start_ok) begin
            score_q[0]  <= '0;
            score_q[1]  <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            draw_q      <= 1'b0;
        end else begin
            score_q[0] <= score_d[0];
            score_q[1] <= score_d[1];
            if (|reach) begin
                game_over_q <= 1'b1;
                draw_q      <= &reach;
                winner_q    <= reach[1] & ~reach[0];
            end
        end
    end

    assign bus.red_explosion_flag  = (state[0] == ST_RESPAWN);
    assign bus.blue_explosion_flag = (state[1] == ST_RESPAWN);
    assign bus.red_boom            = (state[0] == ST_EXPLODE);
    assign bus.blue_boom           = (state[1] == ST_EXPLODE);
    assign bus.red_move_en         = ((state[0] == ST_ALIVE) || (state[0] == ST_INVULN)) && !game_over_q;
    assign bus.blue_move_en        = ((state[1] == ST_ALIVE) || (state[1] == ST_INVULN)) && !game_over_q;
    // ecnt is cleared whenever a tank leaves EXPLODE, so frame reads 0 elsewhere.
    assign bus.red_frame           = 3'(ecnt[0] / EW'(FRAME_DIV));
    assign bus.blue_frame          = 3'(ecnt[1] / EW'(FRAME_DIV));
    assign bus.red_score           = score_q[0];
    assign bus.blue_score          = score_q[1];
    assign bus.game_over           = game_over_q;
    assign bus.winner              = winner_q;
    assign bus.draw                = draw_q;
endmodule

// File: tb/tb_tank_round_ctrl.sv
// tb_tank_round_ctrl: directed scenarios followed by random stimulus, every
// cycle compared against a tick-counting behavioural model of the round rules.
module tb_tank_round_ctrl;
    localparam int TICK_CNT      = 3;
    localparam int EXPLODE_TICKS = 8;
    localparam int INVULN_TICKS  = 4;
    localparam int WIN_SCORE     = 2;
    localparam int SCORE_W       = 4;
`ifdef RESPAWN_INVULN_EN
    localparam bit INV_ON = 1'b1;
`else
    localparam bit INV_ON = 1'b0;
`endif

    logic clk25 = 1'b0;
    logic reset;

    tank_round_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

    tank_round_ctrl #(
        .TICK_CNT      (TICK_CNT),
        .EXPLODE_TICKS (EXPLODE_TICKS),
        .INVULN_TICKS  (INVULN_TICKS),
        .WIN_SCORE     (WIN_SCORE),
        .SCORE_W       (SCORE_W)
    ) dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk25 = ~clk25;

    int checks   = 0;
    int failures = 0;

    // Model: cycles since reset, and per tank what it is doing and how many
    // ticks have elapsed in that activity.
    int m_cyc;
    bit m_expl [2];
    bit m_wait [2];
    bit m_inv  [2];
    int m_ticks[2];
    int m_invt [2];
    int m_score[2];
    bit m_go, m_win, m_draw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        for (int t = 0; t < 2; t++) begin
            m_expl[t] = 0; m_wait[t] = 0; m_inv[t] = 0;
            m_ticks[t] = 0; m_invt[t] = 0; m_score[t] = 0;
        end
        m_go = 0; m_win = 0; m_draw = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit h0, input bit h1,
                              input bit a0, input bit a1);
        bit tick, start_ok;
        bit hit[2], ack[2], acc[2], reached[2];
        if (r) begin
            model_reset();
            return;
        end
        hit[0] = h0; hit[1] = h1; ack[0] = a0; ack[1] = a1;
        tick     = (m_cyc % (TICK_CNT + 1)) == TICK_CNT;
        start_ok = s && m_go;
        for (int t = 0; t < 2; t++)
            acc[t] = hit[t] && !m_expl[t] && !m_wait[t] && !m_inv[t] && !m_go;
        for (int t = 0; t < 2; t++) begin
            if (m_expl[t]) begin
                if (tick) begin
                    m_ticks[t]++;
                    if (m_ticks[t] == EXPLODE_TICKS) begin
                        m_expl[t] = 0; m_wait[t] = 1; m_ticks[t] = 0;
                    end
                end
            end else if (m_wait[t]) begin
                if (ack[t]) begin
                    m_wait[t] = 0; m_inv[t] = INV_ON; m_invt[t] = 0;
                end
            end else if (m_inv[t]) begin
                if (tick) begin
                    m_invt[t]++;
                    if (m_invt[t] == INVULN_TICKS) m_inv[t] = 0;
                end
            end else if (acc[t]) begin
                m_expl[t] = 1; m_ticks[t] = 0;
            end
        end
        if (start_ok) begin
            m_score[0] = 0; m_score[1] = 0; m_go = 0; m_win = 0; m_draw = 0;
        end else begin
            for (int t = 0; t < 2; t++) begin
                reached[t] = 0;
                if (acc[1-t] && m_score[t] < WIN_SCORE) begin
                    m_score[t]++;
                    reached[t] = (m_score[t] == WIN_SCORE);
                end
            end
            if (reached[0] || reached[1]) begin
                m_go   = 1;
                m_draw = reached[0] && reached[1];
                m_win  = reached[1] && !reached[0];
            end
        end
        m_cyc++;
    endtask

    task automatic check_outputs();
        int fdiv;
        fdiv = EXPLODE_TICKS / 8;
        check("red_flag",   bus.red_explosion_flag,  m_wait[0]);
        check("blue_flag",  bus.blue_explosion_flag, m_wait[1]);
        check("red_boom",   bus.red_boom,  m_expl[0]);
        check("blue_boom",  bus.blue_boom, m_expl[1]);
        check("red_frame",  bus.red_frame,  m_expl[0] ? m_ticks[0] / fdiv : 0);
        check("blue_frame", bus.blue_frame, m_expl[1] ? m_ticks[1] / fdiv : 0);
        check("red_move_en",  bus.red_move_en,  !m_expl[0] && !m_wait[0] && !m_go);
        check("blue_move_en", bus.blue_move_en, !m_expl[1] && !m_wait[1] && !m_go);
        check("red_score",  bus.red_score,  m_score[0]);
        check("blue_score", bus.blue_score, m_score[1]);
        check("game_over",  bus.game_over, m_go);
        check("winner",     bus.winner, m_win);
        check("draw",       bus.draw, m_draw);
    endtask

    // One clock: capture the applied inputs, advance DUT and model, compare.
    task automatic step();
        bit r, s, h0, h1, a0, a1;
        r = reset; s = bus.start; h0 = bus.hit_red; h1 = bus.hit_blue;
        a0 = bus.red_explosion_ack; a1 = bus.blue_explosion_ack;
        @(posedge clk25);
        model_step(r, s, h0, h1, a0, a1);
        #1;
        check_outputs();
    endtask

    task automatic wait_flags(input bit want_r, input bit want_b);
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            if ((!want_r || bus.red_explosion_flag) && (!want_b || bus.blue_explosion_flag)) begin
                ok = 1;
                break;
            end
            step();
        end
        check("flag_wait_timeout", ok, 1);
    endtask

    task automatic hits(input bit r, input bit b);
        bus.hit_red = r; bus.hit_blue = b;
        step();
        bus.hit_red = 0; bus.hit_blue = 0;
    endtask

    task automatic acks(input bit r, input bit b);
        bus.red_explosion_ack = r; bus.blue_explosion_ack = b;
        step();
        bus.red_explosion_ack = 0; bus.blue_explosion_ack = 0;
    endtask

    initial begin
        reset = 1;
        bus.start = 0; bus.hit_red = 0; bus.hit_blue = 0;
        bus.red_explosion_ack = 0; bus.blue_explosion_ack = 0;
        model_reset();
        step(); step();
        reset = 0;
        repeat (20) step();
        check("idle_red_move_en", bus.red_move_en, 1);
        check("idle_blue_move_en", bus.blue_move_en, 1);
        check("idle_game_over", bus.game_over, 0);

        // Single red hit, re-hit during explosion, delayed ack.
        hits(1, 0);
        check("hit_red_boom", bus.red_boom, 1);
        check("hit_red_move_en", bus.red_move_en, 0);
        check("hit_blue_score", bus.blue_score, 1);
        repeat (6) step();
        hits(1, 0);
        wait_flags(1, 0);
        check("explode_rehit_score", bus.blue_score, 1);
        repeat (3) step();
        acks(1, 0);
        check("ack_flag_drop", bus.red_explosion_flag, 0);

        // Hit right after respawn: immune with invulnerability, scores without.
        hits(1, 0);
`ifdef RESPAWN_INVULN_EN
        check("invuln_hit_ignored", bus.blue_score, 1);
        repeat (INVULN_TICKS * (TICK_CNT + 1) + 2) step();
        hits(1, 0);
`endif
        check("second_hit_score", bus.blue_score, 2);
        check("blue_wins", bus.winner, 1);

        // Reset while the respawn flag is held, then a stale ack.
        wait_flags(1, 0);
        reset = 1; step(); reset = 0;
        check("reset_flag", bus.red_explosion_flag, 0);
        check("reset_score", bus.blue_score, 0);
        acks(1, 0);
        repeat (4) step();
        check("stale_ack_boom", bus.red_boom, 0);

        // Two simultaneous double hits -> draw.
        hits(1, 1);
        wait_flags(1, 1);
        acks(1, 1);
`ifdef RESPAWN_INVULN_EN
        repeat (INVULN_TICKS * (TICK_CNT + 1) + 2) step();
`endif
        step();
        hits(1, 1);
        check("draw_flag", bus.draw, 1);
        check("draw_winner", bus.winner, 0);
        check("draw_game_over", bus.game_over, 1);
        check("draw_red_move_en", bus.red_move_en, 0);
        wait_flags(1, 1);
        acks(1, 1);
        step();
        hits(0, 1);
        check("go_hit_ignored", bus.red_score, 2);

        // start together with a hit in game_over: start wins.
        bus.start = 1;
        hits(1, 0);
        bus.start = 0;
        check("start_scores", bus.red_score, 0);
        check("start_game_over", bus.game_over, 0);
        check("start_move_en", bus.red_move_en, 1);

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            reset                  = ($urandom_range(0, 199) == 0);
            bus.start              = ($urandom_range(0, 15) == 0);
            bus.hit_red            = ($urandom_range(0, 9) == 0);
            bus.hit_blue           = ($urandom_range(0, 9) == 0);
            bus.red_explosion_ack  = ($urandom_range(0, 2) == 0);
            bus.blue_explosion_ack = ($urandom_range(0, 2) == 0);
            step();
        end
        reset = 0; bus.start = 0; bus.hit_red = 0; bus.hit_blue = 0;
        bus.red_explosion_ack = 0; bus.blue_explosion_ack = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tank_round_ctrl.md
# tank_round_ctrl

Round and respawn controller for the two-tank game. It turns single-cycle hit pulses from bullet collision logic into a per-tank sequence: explosion animation, then respawn handshake with the tank movement block, then optional invulnerability. Alongside that it gates player movement, keeps both scores and declares the winner. It sits between collision detection, the two tank instances (`explosion_flag`/`explosion_ack` pairs) and the sprite/score renderer.

## Interface
Parameters:
- `TICK_CNT`, default 500000: tick divider terminal count; one tick every TICK_CNT+1 clocks.
- `EXPLODE_TICKS`, default 32: explosion duration in ticks; must be a multiple of 8 and ≥8.
- `INVULN_TICKS`, default 64: post-respawn hit immunity in ticks. Used only with `RESPAWN_INVULN_EN`.
- `WIN_SCORE`, default 9: score that ends the round.
- `SCORE_W`, default 4: score width; WIN_SCORE < 2^SCORE_W.

Ports:
- `clk25` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: restart pulse; honoured only when game_over=1.
- `hit_red`, `hit_blue` in 1: single-cycle hit pulses for the red and blue tank.
- `red_explosion_ack`, `blue_explosion_ack` in 1: respawn acknowledge from each tank.
- `red_explosion_flag`, `blue_explosion_flag` out 1: respawn request to each tank.
- `red_move_en`, `blue_move_en` out 1: player input enable.
- `red_boom`, `blue_boom` out 1: explosion sprite active.
- `red_frame`, `blue_frame` out 3: explosion animation frame 0..7.
- `red_score`, `blue_score` out SCORE_W: round scores.
- `game_over` out 1: round finished.
- `winner` out 1: 0 = red, 1 = blue. Valid while game_over=1 and draw=0.
- `draw` out 1: both tanks reached WIN_SCORE in the same cycle.

## Operation
- Free-running tick divider, identical in form to the tank speed counter. Count 0..TICK_CNT. `tick` is a 1-cycle internal pulse when the count wraps.
- Per-tank FSM states: ALIVE, EXPLODE, RESPAWN, INVULN.
- ALIVE: move_en=1 (0 if game_over). A hit moves the tank to EXPLODE and increments the opponent's score, saturating at WIN_SCORE.
- EXPLODE: boom=1, move_en=0. Tick counter counts 0..EXPLODE_TICKS-1. frame = count/(EXPLODE_TICKS/8). On the tick ending the last count, go to RESPAWN.
- RESPAWN: explosion_flag=1, boom=0, move_en=0. Hold until ack is sampled high, then go to INVULN (macro on) or ALIVE (macro off). Ack sampled in any other state is ignored.
- INVULN: move_en=1; hits ignored; after INVULN_TICKS ticks, go to ALIVE.
- Hits in EXPLODE, RESPAWN or INVULN are ignored and do not score.
- Round logic:
  - When either score becomes WIN_SCORE, game_over=1 and winner is set. If both reach it in the same cycle: draw=1, winner=0.
  - While game_over=1: hits are ignored, move_en=0 for both tanks; EXPLODE/RESPAWN sequences already in progress still complete.
  - start while game_over=1 clears scores, game_over, winner and draw. Tanks in ALIVE/INVULN stay there. start while game_over=0 has no effect.
- Simultaneous hit_red and hit_blue while both tanks are ALIVE: both explode, both scores increment.

## Timing
- Reset values: all flags, boom, frame, scores, game_over, winner, draw = 0; move_en = 1; FSMs ALIVE; tick divider 0.
- Reset mid-sequence aborts immediately to the reset values. A flag held in RESPAWN drops the cycle after reset is sampled.
- Hit sampled at edge N: state=EXPLODE, boom=1, move_en=0, score updated, all registered, visible after edge N.
- game_over asserts on the same edge as the final score update.
- Explosion length is EXPLODE_TICKS ticks, but the first tick may arrive anywhere from 1 to TICK_CNT+1 cycles after entry. The EXPLODE tick counter clears on entry.
- Ack sampled at edge M: flag=0 after edge M. Zero-cycle ack (ack already high on RESPAWN entry) is sampled on the first RESPAWN cycle, so the flag is high for exactly 1 cycle.
- start and a hit in the same cycle during game_over: start wins, the hit is ignored.

## Configuration
- `RESPAWN_INVULN_EN` defined: the INVULN state exists; a tank is immune for INVULN_TICKS ticks after ack.
- Not defined: INVULN is not built and INVULN_TICKS is unused. RESPAWN goes straight to ALIVE on ack, and a hit in the next cycle is accepted.

## Test plan
All scenarios use TICK_CNT=3, EXPLODE_TICKS=8, WIN_SCORE=2.
- Reset, then idle 20 cycles -> flags 0, move_en 1/1, scores 0/0, game_over 0.
- hit_red pulse -> next cycle red_boom=1, red_move_en=0, blue_score=1. red_frame steps 0..7 once per tick. After 8 ticks, red_explosion_flag=1. Drive ack 3 cycles later -> flag 0 the next cycle, then red_move_en=1.
- hit_red during red EXPLODE -> ignored, blue_score stays 1. With the macro on, a hit_red within INVULN_TICKS after ack is also ignored; with it off, a hit_red 1 cycle after ack scores.
- hit_red and hit_blue simultaneously, twice (with respawn between) -> scores 2/2, game_over=1, draw=1, both move_en=0.
- In game_over, pulse hit_blue -> no change. Then pulse start -> scores 0/0, game_over=0, draw=0, move_en=1 for ALIVE tanks.
- Assert reset while red_explosion_flag=1 -> flag 0, FSM ALIVE, scores 0 after the reset edge; a later ack has no effect.
